// File: rtl/glitch_filter_pkg.sv
// Shared definitions for the glitch filter: FSM state encoding and default
// qualification parameters.
package glitch_filter_pkg;

  typedef enum logic [1:0] {
    S_LOW      = 2'b00,
    S_CHK_HIGH = 2'b01,
    S_HIGH     = 2'b10,
    S_CHK_LOW  = 2'b11
  } gf_state_t;

  localparam int GF_STABLE_CYCLES = 4;
  localparam int GF_CNT_W         = 4;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer that brings the asynchronous glitchy level into the
// clk domain; cleared to 0 by the asynchronous reset.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/glitch_filter.sv
// Debounce/glitch filter: a level must be seen for STABLE_CYCLES consecutive
// enabled samples before dout follows it. Define GLITCH_FILTER_EDGE_EN for rise/fall pulses.
module glitch_filter
  import glitch_filter_pkg::*;
#(
  parameter int STABLE_CYCLES = GF_STABLE_CYCLES,
  parameter int CNT_W         = GF_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  input  logic en,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             sync;
  gf_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dout_q, dout_d;
  logic             busy_q, busy_d;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (din),
    .q     (sync)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (en) begin
      unique case (state_q)
        S_LOW: begin
          if (sync) begin
            if (STABLE_CYCLES == 1) begin
              state_d = S_HIGH;
            end else begin
              state_d = S_CHK_HIGH;
              cnt_d   = CNT_ONE;
            end
          end
        end
        S_CHK_HIGH: begin
          // cnt already counts the current run, so cnt == N-1 means this sample is the Nth
          if (!sync) begin
            state_d = S_LOW;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = S_HIGH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_HIGH: begin
          if (!sync) begin
            if (STABLE_CYCLES == 1) begin
              state_d = S_LOW;
            end else begin
              state_d = S_CHK_LOW;
              cnt_d   = CNT_ONE;
            end
          end
        end
        S_CHK_LOW: begin
          if (sync) begin
            state_d = S_HIGH;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = S_LOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = S_LOW;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they land in the same cycle as the state.
  always_comb begin
    dout_d = (state_d == S_HIGH) || (state_d == S_CHK_LOW);
    busy_d = (state_d == S_CHK_HIGH) || (state_d == S_CHK_LOW);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_LOW;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
    end
  end

  assign dout = dout_q;
  assign busy = busy_q;

`ifdef GLITCH_FILTER_EDGE_EN
  logic rise_q;
  logic fall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= dout_d & ~dout_q;
      fall_q <= ~dout_d & dout_q;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule
